// File: rtl/adder_result_accumulator.sv
// -----------------------------------------------------------------------------
// adder_result_accumulator
//
// Downstream consumer of a ripple-carry adder result {carry, sum}. A run is
// started with a one-cycle start pulse that carries the number of results to
// collect. During the run, each accepted {in_carry, in_sum} beat is added into
// a wide accumulator. When the programmed number of beats has been accepted,
// the total is presented on a valid/ready output handshake.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      one-cycle pulse that begins a run (sampled only in IDLE)
//   num_samples  in   CNT_W  number of results to accumulate, sampled with start
//   in_valid     in   1      adder result valid
//   in_ready     out  1      a result is accepted this cycle (ACCUM)
//   in_sum       in   IN_W   adder sum
//   in_carry     in   1      adder carry-out
//   out_valid    out  1      run complete; out_* are stable
//   out_ready    in   1      consumer takes the result
//   out_acc      out  ACC_W  accumulated total, modulo 2^ACC_W
//   out_count    out  CNT_W  number of samples accepted in this run
//   out_ovf      out  1      sticky: the accumulator wrapped during this run
//   busy         out  1      high in ACCUM or DONE
// -----------------------------------------------------------------------------
module adder_result_accumulator #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;

    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   target_r;
    logic               ovf_r;

    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic               in_ready_s;
    logic               out_valid_s;
    logic               busy_s;

    logic               beat_s;
    logic               last_beat_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic [ACC_W:0]     addend_s;
    logic [ACC_W:0]     sum_s;

    // Beat acceptance and the widened add; the extra top bit of sum_s is the
    // accumulator carry that feeds the sticky overflow flag.
    always_comb begin
        beat_s      = (state_r == ST_ACCUM) && in_valid;
        count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        last_beat_s = beat_s && (count_inc_s == target_r);
        addend_s    = {{(ACC_W-IN_W){1'b0}}, in_carry, in_sum};
        sum_s       = {1'b0, acc_r} + addend_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. start only matters in IDLE; a zero-length run goes
    // straight to DONE so the consumer still sees a (zero) result.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_samples != {CNT_W{1'b0}}) begin
                        state_s = ST_ACCUM;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_beat_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered handshake flags
    // line up exactly with the state they describe.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_s)
            ST_IDLE: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
            ST_ACCUM: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                busy_s      = 1'b1;
            end
            ST_DONE: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Handshake flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

    // Accumulator datapath. Results are held in DONE and after returning to
    // IDLE; they are only cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {ACC_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            target_r <= {CNT_W{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r    <= {ACC_W{1'b0}};
                        count_r  <= {CNT_W{1'b0}};
                        target_r <= num_samples;
                        ovf_r    <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (beat_s) begin
                        acc_r   <= sum_s[ACC_W-1:0];
                        ovf_r   <= ovf_r | sum_s[ACC_W];
                        count_r <= count_inc_s;
                    end
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_acc   = acc_r;
    assign out_count = count_r;
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// -----------------------------------------------------------------------------
// tb_adder_result_accumulator
//
// Two instances share every input: the default 12-bit accumulator (suffix _a)
// and an 8-bit accumulator (suffix _b) so that wrap-around is reachable.
// Expected results come from a plain integer running total: the accumulator
// must equal total mod 2^ACC_W and the sticky flag must equal total >= 2^ACC_W.
// -----------------------------------------------------------------------------
module tb_adder_result_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  num_samples;
    logic        in_valid;
    logic [3:0]  in_sum;
    logic        in_carry;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
    logic [11:0] out_acc_a;
    logic [3:0]  out_count_a;
    logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
    logic [7:0]  out_acc_b;
    logic [3:0]  out_count_b;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    adder_result_accumulator #(.IN_W(4), .ACC_W(12), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
        .out_count(out_count_a), .out_ovf(out_ovf_a), .busy(busy_a)
    );

    adder_result_accumulator #(.IN_W(4), .ACC_W(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
        .out_count(out_count_b), .out_ovf(out_ovf_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int n);
        num_samples = 4'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        num_samples = 4'($urandom);
    endtask

    task automatic beat(input logic [3:0] s, input logic c);
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        tick();
        in_valid = 1'b0;
        in_sum   = 4'($urandom);
        in_carry = 1'($urandom);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tot_cnt++; if ({out_valid_a, in_ready_a, busy_a, out_ovf_a} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {out_valid_a, in_ready_a, busy_a, out_ovf_a}); else pass_cnt++;
        tot_cnt++; if ({out_acc_a, out_count_a} !== 16'h0000) $display("FAIL reset_acc_cnt: got %h want 0000", {out_acc_a, out_count_a}); else pass_cnt++;
        tot_cnt++; if ({out_valid_b, in_ready_b, busy_b, out_ovf_b, out_acc_b} !== 12'h000) $display("FAIL reset_b: got %h want 000", {out_valid_b, in_ready_b, busy_b, out_ovf_b, out_acc_b}); else pass_cnt++;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        tot_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", busy_a); else pass_cnt++;
    endtask

    task automatic test_basic();
        pulse_start(3);
        tot_cnt++; if ({in_ready_a, busy_a, out_valid_a} !== 3'b110) $display("FAIL basic_accum_flags: got %b want 110", {in_ready_a, busy_a, out_valid_a}); else pass_cnt++;
        beat(4'hF, 1'b1);
        beat(4'hF, 1'b1);
        tot_cnt++; if (out_valid_a !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid_a); else pass_cnt++;
        beat(4'hF, 1'b1);
        tot_cnt++; if ({out_valid_a, in_ready_a} !== 2'b10) $display("FAIL basic_done_flags: got %b want 10", {out_valid_a, in_ready_a}); else pass_cnt++;
        tot_cnt++; if (out_acc_a !== 12'h05D) $display("FAIL basic_acc: got %h want 05d", out_acc_a); else pass_cnt++;
        tot_cnt++; if ({out_count_a, out_ovf_a} !== {4'd3, 1'b0}) $display("FAIL basic_cnt_ovf: got %0d/%b want 3/0", out_count_a, out_ovf_a); else pass_cnt++;
        release_out();
        tot_cnt++; if ({out_valid_a, busy_a} !== 2'b00) $display("FAIL basic_release: got %b want 00", {out_valid_a, busy_a}); else pass_cnt++;
        tot_cnt++; if (out_acc_a !== 12'h05D) $display("FAIL basic_hold_idle: got %h want 05d", out_acc_a); else pass_cnt++;
    endtask

    task automatic test_overflow();
        pulse_start(9);
        for (int i = 0; i < 9; i++) beat(4'hF, 1'b1);
        tot_cnt++; if (out_valid_b !== 1'b1) $display("FAIL ovf_valid: got %b want 1", out_valid_b); else pass_cnt++;
        tot_cnt++; if (out_acc_b !== 8'h17) $display("FAIL ovf_acc8: got %h want 17", out_acc_b); else pass_cnt++;
        tot_cnt++; if ({out_ovf_b, out_count_b} !== {1'b1, 4'd9}) $display("FAIL ovf_flag8: got %b/%0d want 1/9", out_ovf_b, out_count_b); else pass_cnt++;
        tot_cnt++; if ({out_ovf_a, out_acc_a} !== {1'b0, 12'h117}) $display("FAIL ovf_acc12: got %b/%h want 0/117", out_ovf_a, out_acc_a); else pass_cnt++;
        release_out();
    endtask

    task automatic test_gaps_backpressure();
        int total;
        logic [3:0] s;
        logic c;
        total = 0;
        pulse_start(2);
        for (int i = 0; i < 2; i++) begin
            repeat (3) tick();
            s = 4'($urandom); c = 1'($urandom);
            total += int'({c, s});
            beat(s, c);
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_sum = 4'($urandom); in_carry = 1'b1;
            start = 1'b1; num_samples = 4'd5;
            tick();
            tot_cnt++; if ({out_valid_a, in_ready_a, busy_a} !== 3'b101) $display("FAIL bp_flags_%0d: got %b want 101", k, {out_valid_a, in_ready_a, busy_a}); else pass_cnt++;
            tot_cnt++; if ({out_acc_a, out_count_a} !== {12'(total), 4'd2}) $display("FAIL bp_hold_%0d: got %h/%0d want %h/2", k, out_acc_a, out_count_a, 12'(total)); else pass_cnt++;
        end
        in_valid = 1'b0;
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        tot_cnt++; if ({out_valid_a, busy_a, in_ready_a} !== 3'b000) $display("FAIL bp_release: got %b want 000", {out_valid_a, busy_a, in_ready_a}); else pass_cnt++;
        tick();
        tot_cnt++; if (busy_a !== 1'b0) $display("FAIL bp_start_ignored: busy got %b want 0", busy_a); else pass_cnt++;
        tot_cnt++; if (out_acc_a !== 12'(total)) $display("FAIL bp_idle_hold: got %h want %h", out_acc_a, 12'(total)); else pass_cnt++;
    endtask

    task automatic test_zero_and_start_ignored();
        int total;
        logic [3:0] s;
        logic c;
        pulse_start(0);
        tot_cnt++; if ({out_valid_a, busy_a, in_ready_a} !== 3'b110) $display("FAIL zero_flags: got %b want 110", {out_valid_a, busy_a, in_ready_a}); else pass_cnt++;
        tot_cnt++; if ({out_acc_a, out_count_a, out_ovf_a} !== 17'h0) $display("FAIL zero_vals: got %h want 0", {out_acc_a, out_count_a, out_ovf_a}); else pass_cnt++;
        release_out();
        total = 0;
        pulse_start(3);
        s = 4'($urandom); c = 1'($urandom); total += int'({c, s}); beat(s, c);
        num_samples = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tot_cnt++; if ({in_ready_a, out_count_a} !== {1'b1, 4'd1}) $display("FAIL restart_cnt: got %b/%0d want 1/1", in_ready_a, out_count_a); else pass_cnt++;
        s = 4'($urandom); c = 1'($urandom); total += int'({c, s}); beat(s, c);
        tot_cnt++; if (out_valid_a !== 1'b0) $display("FAIL restart_early_done: got %b want 0", out_valid_a); else pass_cnt++;
        s = 4'($urandom); c = 1'($urandom); total += int'({c, s}); beat(s, c);
        tot_cnt++; if ({out_valid_a, out_count_a, out_acc_a} !== {1'b1, 4'd3, 12'(total)}) $display("FAIL restart_result: got %b/%0d/%h want 1/3/%h", out_valid_a, out_count_a, out_acc_a, 12'(total)); else pass_cnt++;
        release_out();
    endtask

    task automatic test_reset_mid_run();
        pulse_start(4);
        beat(4'h9, 1'b1);
        beat(4'h7, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        tot_cnt++; if ({out_valid_a, in_ready_a, busy_a, out_ovf_a} !== 4'b0000) $display("FAIL midrst_flags: got %b want 0000", {out_valid_a, in_ready_a, busy_a, out_ovf_a}); else pass_cnt++;
        tot_cnt++; if ({out_acc_a, out_count_a} !== 16'h0000) $display("FAIL midrst_vals: got %h want 0000", {out_acc_a, out_count_a}); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start(1);
        beat(4'h5, 1'b0);
        tot_cnt++; if ({out_valid_a, out_acc_a, out_count_a} !== {1'b1, 12'd5, 4'd1}) $display("FAIL midrst_fresh: got %b/%h/%0d want 1/005/1", out_valid_a, out_acc_a, out_count_a); else pass_cnt++;
        release_out();
    endtask

    task automatic test_random();
        int n, total, gaps, bp;
        logic [3:0] s;
        logic c;
        for (int r = 0; r < 20; r++) begin
            in_valid = 1'b1; in_sum = 4'($urandom); in_carry = 1'($urandom);
            tick();
            in_valid = 1'b0;
            tot_cnt++; if (busy_a !== 1'b0) $display("FAIL rnd%0d_idle_invalid: busy got %b want 0", r, busy_a); else pass_cnt++;
            n = int'($urandom_range(0, 15));
            total = 0;
            pulse_start(n);
            for (int i = 0; i < n; i++) begin
                gaps = int'($urandom_range(0, 2));
                repeat (gaps) tick();
                s = 4'($urandom); c = 1'($urandom);
                total += int'({c, s});
                beat(s, c);
            end
            tot_cnt++; if ({out_valid_a, out_valid_b} !== 2'b11) $display("FAIL rnd%0d_valid: got %b want 11", r, {out_valid_a, out_valid_b}); else pass_cnt++;
            tot_cnt++; if ({out_acc_a, out_ovf_a} !== {12'(total % 4096), total >= 4096}) $display("FAIL rnd%0d_acc12: got %h/%b want %h/%b", r, out_acc_a, out_ovf_a, 12'(total % 4096), total >= 4096); else pass_cnt++;
            tot_cnt++; if ({out_acc_b, out_ovf_b} !== {8'(total % 256), total >= 256}) $display("FAIL rnd%0d_acc8: got %h/%b want %h/%b", r, out_acc_b, out_ovf_b, 8'(total % 256), total >= 256); else pass_cnt++;
            tot_cnt++; if (out_count_a !== 4'(n)) $display("FAIL rnd%0d_count: got %0d want %0d", r, out_count_a, n); else pass_cnt++;
            bp = int'($urandom_range(0, 3));
            repeat (bp) tick();
            release_out();
            tot_cnt++; if ({out_valid_a, busy_a} !== 2'b00) $display("FAIL rnd%0d_release: got %b want 00", r, {out_valid_a, busy_a}); else pass_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; num_samples = 4'd0;
        in_valid = 1'b0; in_sum = 4'd0; in_carry = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_gaps_backpressure();
        test_zero_and_start_ignored();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
